ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg_if.sv | 52 +++++
 rtl/ex_mem_reg.sv | 61 ++++++
 tb/tb_ex_mem_reg.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bus: EX-side instruction fields in, MEM-side registered copies out.
// master = EX stage / hazard unit driving the *_i fields; slave = the EX/MEM register.
interface ex_mem_reg_if #(
   parameter int REGISTER_LENGTH = 64,
   parameter int REG_ADDR_LENGTH = 5
);
   // Transfer rule: an instruction moves into MEM on a clock edge when stall_i is low and
   // flush_i is low; valid_i marks it real. flush_i turns that edge into a bubble, even
   // under stall_i. While stall_i alone is high the register holds everything.
   logic                       stall_i;
   logic                       flush_i;
   logic                       valid_i;
   logic [REGISTER_LENGTH-1:0] result_i;
   logic                       negative_i;
   logic                       zero_i;
   logic                       carryout_i;
   logic                       overflow_i;
   logic                       set_flags_i;
   logic [REGISTER_LENGTH-1:0] store_data_i;
   logic [REG_ADDR_LENGTH-1:0] dest_reg_i;
   logic                       reg_write_i;
   logic                       mem_read_i;
   logic                       mem_write_i;
   logic                       mem_to_reg_i;

   logic                       valid_o;
   logic [REGISTER_LENGTH-1:0] result_o;
   logic [REGISTER_LENGTH-1:0] store_data_o;
   logic [REG_ADDR_LENGTH-1:0] dest_reg_o;
   logic                       reg_write_o;
   logic                       mem_read_o;
   logic                       mem_write_o;
   logic                       mem_to_reg_o;
   logic [3:0]                 flags_o;
   logic [3:0]                 flags_bypass_o;

   modport master (
      output stall_i, flush_i, valid_i, result_i, negative_i, zero_i, carryout_i,
             overflow_i, set_flags_i, store_data_i, dest_reg_i, reg_write_i,
             mem_read_i, mem_write_i, mem_to_reg_i,
      input  valid_o, result_o, store_data_o, dest_reg_o, reg_write_o, mem_read_o,
             mem_write_o, mem_to_reg_o, flags_o, flags_bypass_o
   );

   modport slave (
      input  stall_i, flush_i, valid_i, result_i, negative_i, zero_i, carryout_i,
             overflow_i, set_flags_i, store_data_i, dest_reg_i, reg_write_i,
             mem_read_i, mem_write_i, mem_to_reg_i,
      output valid_o, result_o, store_data_o, dest_reg_o, reg_write_o, mem_read_o,
             mem_write_o, mem_to_reg_o, flags_o, flags_bypass_o
   );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush control and the architectural NZCV flags register.
// flags_bypass_o exposes the flags the EX instruction is about to commit, for branch resolution.
module ex_mem_reg #(
   parameter int REGISTER_LENGTH = 64,
   parameter int REG_ADDR_LENGTH = 5
) (
   input logic          clk_i,
   input logic          reset_i,
   ex_mem_reg_if.slave  bus
);
   logic                       valid_q;
   logic [REGISTER_LENGTH-1:0] result_q;
   logic [REGISTER_LENGTH-1:0] store_data_q;
   logic [REG_ADDR_LENGTH-1:0] dest_reg_q;
   logic [3:0]                 ctrl_q;   // {reg_write, mem_read, mem_write, mem_to_reg}
   logic [3:0]                 flags_q;  // {N, Z, C, V}

   logic [3:0] alu_flags;
   logic [3:0] ctrl_in;
   logic       flags_commit;

   assign alu_flags    = {bus.negative_i, bus.zero_i, bus.carryout_i, bus.overflow_i};
   assign ctrl_in      = {bus.reg_write_i, bus.mem_read_i, bus.mem_write_i, bus.mem_to_reg_i};
   assign flags_commit = bus.valid_i & bus.set_flags_i & ~bus.flush_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q      <= 1'b0;
         result_q     <= '0;
         store_data_q <= '0;
         dest_reg_q   <= '0;
         ctrl_q       <= 4'b0000;
         flags_q      <= 4'b0000;
      end else if (bus.flush_i) begin
         // Bubble: kill the instruction but leave the datapath fields as they were.
         valid_q <= 1'b0;
         ctrl_q  <= 4'b0000;
      end else if (!bus.stall_i) begin
         valid_q      <= bus.valid_i;
         result_q     <= bus.result_i;
         store_data_q <= bus.store_data_i;
         dest_reg_q   <= bus.dest_reg_i;
         ctrl_q       <= ctrl_in & {4{bus.valid_i}};
         if (bus.valid_i && bus.set_flags_i) begin
            flags_q <= alu_flags;
         end
      end
   end

   assign bus.valid_o        = valid_q;
   assign bus.result_o       = result_q;
   assign bus.store_data_o   = store_data_q;
   assign bus.dest_reg_o     = dest_reg_q;
   assign bus.reg_write_o    = ctrl_q[3];
   assign bus.mem_read_o     = ctrl_q[2];
   assign bus.mem_write_o    = ctrl_q[1];
   assign bus.mem_to_reg_o   = ctrl_q[0];
   assign bus.flags_o        = flags_q;
   // Deliberately ignores stall_i: a stalled branch still sees the flags it is waiting on.
   assign bus.flags_bypass_o = flags_commit ? alu_flags : flags_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus randomized traffic against a
// "what does the MEM stage hold" reference model.
module tb_ex_mem_reg;
   localparam int RL  = 64;
   localparam int RAL = 5;

   typedef struct packed {
      logic           valid;
      logic [RL-1:0]  result;
      logic [RL-1:0]  store;
      logic [RAL-1:0] dest;
      logic           rw;
      logic           mr;
      logic           mw;
      logic           m2r;
      logic [3:0]     flags;
   } mem_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   mem_t m;     // reference: contents the MEM stage should hold
   mem_t snap;

   ex_mem_reg_if #(.REGISTER_LENGTH(RL), .REG_ADDR_LENGTH(RAL)) bus ();

   ex_mem_reg #(.REGISTER_LENGTH(RL), .REG_ADDR_LENGTH(RAL)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.stall_i = 0; bus.flush_i = 0; bus.valid_i = 0; bus.result_i = '0;
      bus.negative_i = 0; bus.zero_i = 0; bus.carryout_i = 0; bus.overflow_i = 0;
      bus.set_flags_i = 0; bus.store_data_i = '0; bus.dest_reg_i = '0;
      bus.reg_write_i = 0; bus.mem_read_i = 0; bus.mem_write_i = 0; bus.mem_to_reg_i = 0;
   endtask

   task automatic drive_random(input int p_stall, input int p_flush);
      bus.stall_i      = ($urandom_range(0, 99) < p_stall);
      bus.flush_i      = ($urandom_range(0, 99) < p_flush);
      bus.valid_i      = ($urandom_range(0, 99) < 75);
      bus.result_i     = {$urandom, $urandom};
      bus.store_data_i = {$urandom, $urandom};
      bus.dest_reg_i   = RAL'($urandom);
      {bus.negative_i, bus.zero_i, bus.carryout_i, bus.overflow_i} = 4'($urandom);
      bus.set_flags_i  = $urandom_range(0, 1);
      {bus.reg_write_i, bus.mem_read_i, bus.mem_write_i, bus.mem_to_reg_i} = 4'($urandom);
   endtask

   // Instruction movement rules: reset empties the stage; a flush leaves an empty
   // slot (old data fields stay visible); a stall keeps the old instruction; otherwise
   // the EX instruction moves in, and only a real flag-setter rewrites NZCV.
   task automatic model_edge();
      if (reset) begin
         m = '0;
      end else if (bus.flush_i) begin
         m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
      end else if (!bus.stall_i) begin
         m.valid  = bus.valid_i;
         m.result = bus.result_i;
         m.store  = bus.store_data_i;
         m.dest   = bus.dest_reg_i;
         if (bus.valid_i) begin
            {m.rw, m.mr, m.mw, m.m2r} =
               {bus.reg_write_i, bus.mem_read_i, bus.mem_write_i, bus.mem_to_reg_i};
            if (bus.set_flags_i)
               m.flags = {bus.negative_i, bus.zero_i, bus.carryout_i, bus.overflow_i};
         end else begin
            {m.rw, m.mr, m.mw, m.m2r} = 4'b0000;
         end
      end
   endtask

   function automatic logic [3:0] exp_bypass();
      if (bus.valid_i && bus.set_flags_i && !bus.flush_i)
         return {bus.negative_i, bus.zero_i, bus.carryout_i, bus.overflow_i};
      return m.flags;
   endfunction

   function automatic mem_t observe();
      mem_t o;
      o.valid = bus.valid_o; o.result = bus.result_o; o.store = bus.store_data_o;
      o.dest = bus.dest_reg_o; o.rw = bus.reg_write_o; o.mr = bus.mem_read_o;
      o.mw = bus.mem_write_o; o.m2r = bus.mem_to_reg_o; o.flags = bus.flags_o;
      return o;
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1;
      drive_random(50, 50);
      bus.valid_i = 1; bus.set_flags_i = 1; bus.negative_i = 1;
      step();
      step();
      checks++;
      if (observe() !== mem_t'('0)) begin
         failures++;
         $display("FAIL reset_state got=%h exp=0", observe());
      end
      reset = 0;
      clear_inputs();
   endtask

   task automatic test_add();
      clear_inputs();
      bus.valid_i = 1; bus.result_i = 64'h5; bus.dest_reg_i = 5'd3; bus.reg_write_i = 1;
      step();
      checks++;
      if (bus.valid_o !== 1'b1 || bus.result_o !== 64'h5 || bus.dest_reg_o !== 5'd3 ||
          bus.reg_write_o !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.flags_o !== 4'b0000) begin
         failures++;
         $display("FAIL add got v=%b r=%h d=%0d rw=%b mw=%b f=%b exp v=1 r=5 d=3 rw=1 mw=0 f=0000",
                  bus.valid_o, bus.result_o, bus.dest_reg_o, bus.reg_write_o,
                  bus.mem_write_o, bus.flags_o);
      end
   endtask

   task automatic test_subs();
      clear_inputs();
      bus.valid_i = 1; bus.set_flags_i = 1; bus.zero_i = 1; bus.carryout_i = 1;
      bus.result_i = '0; bus.dest_reg_i = 5'd7; bus.reg_write_i = 1;
      #1;
      checks++;
      if (bus.flags_bypass_o !== 4'b0110) begin
         failures++;
         $display("FAIL subs_bypass got=%b exp=0110", bus.flags_bypass_o);
      end
      step();
      checks++;
      if (bus.flags_o !== 4'b0110) begin
         failures++;
         $display("FAIL subs_flags got=%b exp=0110", bus.flags_o);
      end
   endtask

   task automatic test_stall();
      clear_inputs();
      bus.valid_i = 1; bus.mem_read_i = 1; bus.mem_to_reg_i = 1; bus.reg_write_i = 1;
      bus.result_i = 64'h0000_1000_0000_0040; bus.dest_reg_i = 5'd9;
      step();
      snap = observe();
      checks++;
      if (snap !== m) begin
         failures++;
         $display("FAIL stall_load got=%h exp=%h", snap, m);
      end
      for (int i = 0; i < 3; i++) begin
         drive_random(0, 0);
         bus.stall_i = 1; bus.valid_i = 1; bus.set_flags_i = 1;
         step();
         checks++;
         if (observe() !== snap) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, observe(), snap);
         end
      end
   endtask

   task automatic test_flush_stall();
      clear_inputs();
      bus.flush_i = 1; bus.stall_i = 1; bus.valid_i = 1; bus.set_flags_i = 1;
      bus.negative_i = 1; bus.mem_write_i = 1; bus.result_i = {$urandom, $urandom};
      snap = observe();
      #1;
      checks++;
      if (bus.flags_bypass_o !== snap.flags) begin
         failures++;
         $display("FAIL flush_bypass got=%b exp=%b", bus.flags_bypass_o, snap.flags);
      end
      step();
      checks++;
      if (bus.valid_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.reg_write_o !== 1'b0 ||
          bus.flags_o !== snap.flags || bus.result_o !== snap.result ||
          bus.dest_reg_o !== snap.dest) begin
         failures++;
         $display("FAIL flush_stall got v=%b mw=%b rw=%b f=%b r=%h exp v=0 mw=0 rw=0 f=%b r=%h",
                  bus.valid_o, bus.mem_write_o, bus.reg_write_o, bus.flags_o, bus.result_o,
                  snap.flags, snap.result);
      end
   endtask

   task automatic test_invalid();
      clear_inputs();
      snap = observe();
      bus.valid_i = 0; bus.reg_write_i = 1; bus.mem_write_i = 1; bus.set_flags_i = 1;
      bus.negative_i = ~snap.flags[3]; bus.overflow_i = ~snap.flags[0];
      step();
      checks++;
      if (bus.valid_o !== 1'b0 || bus.reg_write_o !== 1'b0 || bus.mem_write_o !== 1'b0 ||
          bus.flags_o !== snap.flags) begin
         failures++;
         $display("FAIL invalid got v=%b rw=%b mw=%b f=%b exp v=0 rw=0 mw=0 f=%b",
                  bus.valid_o, bus.reg_write_o, bus.mem_write_o, bus.flags_o, snap.flags);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq [3] = '{4'b1000, 4'b0011, 4'b1101};
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         bus.valid_i = 1; bus.set_flags_i = 1;
         {bus.negative_i, bus.zero_i, bus.carryout_i, bus.overflow_i} = seq[i];
         step();
         checks++;
         if (bus.flags_o !== seq[i]) begin
            failures++;
            $display("FAIL b2b_flags idx=%0d got=%b exp=%b", i, bus.flags_o, seq[i]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      clear_inputs();
      bus.valid_i = 1; bus.set_flags_i = 1; bus.negative_i = 1; bus.overflow_i = 1;
      bus.reg_write_i = 1; bus.result_i = 64'hDEAD_BEEF; bus.dest_reg_i = 5'd31;
      step();
      checks++;
      if (bus.flags_o !== 4'b1001 || bus.valid_o !== 1'b1) begin
         failures++;
         $display("FAIL midreset_setup got f=%b v=%b exp f=1001 v=1", bus.flags_o, bus.valid_o);
      end
      reset = 1; bus.stall_i = 1; bus.flush_i = 1;
      step();
      checks++;
      if (observe() !== mem_t'('0)) begin
         failures++;
         $display("FAIL midreset_clear got=%h exp=0", observe());
      end
      reset = 0;
      clear_inputs();
      bus.valid_i = 1; bus.mem_write_i = 1; bus.store_data_i = 64'hA5A5; bus.result_i = 64'h20;
      step();
      checks++;
      if (bus.valid_o !== 1'b1 || bus.mem_write_o !== 1'b1 || bus.store_data_o !== 64'hA5A5) begin
         failures++;
         $display("FAIL postreset_capture got v=%b mw=%b sd=%h exp v=1 mw=1 sd=a5a5",
                  bus.valid_o, bus.mem_write_o, bus.store_data_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_random(25, 15);
         reset = ($urandom_range(0, 99) < 3);
         #1;
         checks++;
         if (bus.flags_bypass_o !== exp_bypass()) begin
            failures++;
            $display("FAIL rand_bypass cyc=%0d got=%b exp=%b", i, bus.flags_bypass_o, exp_bypass());
         end
         step();
         checks++;
         if (observe() !== m) begin
            failures++;
            $display("FAIL rand_state cyc=%0d got=%h exp=%h", i, observe(), m);
         end
      end
      reset = 0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      m = '0;
      reset = 1;
      clear_inputs();
      test_reset();
      test_add();
      test_subs();
      test_stall();
      test_flush_stall();
      test_invalid();
      test_back_to_back();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
